// File: rtl/memory_requester_if.sv
// Main-memory line bus between the requester (master) and the memory block (slave).
interface memory_requester_if #(
    parameter int CACHE_LINE_SIZE     = 128,
    parameter int MEMORY_ADDRESS_SIZE = 32
);
    logic                           enable;
    logic                           op;
    logic [MEMORY_ADDRESS_SIZE-1:0] address;
    logic [CACHE_LINE_SIZE-1:0]     wdata;
    logic                           op_init;
    logic                           op_done;
    logic [CACHE_LINE_SIZE-1:0]     rdata;
    logic                           data_ready;

    modport master (
        output enable, op, address, wdata, op_init, op_done,
        input  rdata, data_ready
    );

    modport slave (
        input  enable, op, address, wdata, op_init, op_done,
        output rdata, data_ready
    );
endinterface

// File: rtl/memory_requester.sv
// Initiator side of the main-memory line protocol: round-robin between icache and dcache,
// one transaction in flight, timeout abort, and draining of stale memory responses.
//
// state   | meaning
// IDLE    | arbitrate; leave for DRAIN if memory still shows data_ready
// DRAIN   | pulse op_done to retire a stale response, enable low
// ISSUE   | enable + op_init for one cycle, counter cleared
// WAIT    | enable held, counting until data_ready or timeout
// DONE    | owner ready pulse; op_done unless the op was aborted
module memory_requester #(
    parameter int CACHE_LINE_SIZE     = 128,
    parameter int MEMORY_ADDRESS_SIZE = 32,
    parameter int TIMEOUT_CYCLES      = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ic_req,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] ic_address,
    output logic                           ic_ready,
    output logic [CACHE_LINE_SIZE-1:0]     ic_data,
    input  logic                           dc_req,
    input  logic                           dc_op,
    input  logic [MEMORY_ADDRESS_SIZE-1:0] dc_address,
    input  logic [CACHE_LINE_SIZE-1:0]     dc_wdata,
    output logic                           dc_ready,
    output logic [CACHE_LINE_SIZE-1:0]     dc_rdata,
    output logic                           timeout_err,
    memory_requester_if.master             mem
);
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    localparam logic       OWN_IC       = 1'b0;
    localparam logic       OWN_DC       = 1'b1;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                         state;
    state_t                         next_state;
    logic                           grant_ic;
    logic                           grant_dc;
    logic                           owner;
    logic                           last_grant;
    logic                           op_r;
    logic [MEMORY_ADDRESS_SIZE-1:0] addr_r;
    logic [CACHE_LINE_SIZE-1:0]     wdata_r;
    logic [7:0]                     wait_cnt;
    logic                           abort;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // A pending data_ready always wins over arbitration so the memory sees op_done first.
    always_comb begin
        next_state = state;
        grant_ic   = 1'b0;
        grant_dc   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem.data_ready) begin
                    next_state = S_DRAIN;
                end else if (dc_req && (!ic_req || last_grant == OWN_IC)) begin
                    grant_dc   = 1'b1;
                    next_state = S_ISSUE;
                end else if (ic_req) begin
                    grant_ic   = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_DRAIN: next_state = S_IDLE;
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                if (mem.data_ready || wait_cnt == TIMEOUT_LAST) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem.enable  = 1'b0;
        mem.op_init = 1'b0;
        mem.op_done = 1'b0;
        ic_ready    = 1'b0;
        dc_ready    = 1'b0;
        case (state)
            S_DRAIN: mem.op_done = 1'b1;
            S_ISSUE: begin
                mem.enable  = 1'b1;
                mem.op_init = 1'b1;
            end
            S_WAIT:  mem.enable = 1'b1;
            S_DONE: begin
                mem.op_done = !abort;
                ic_ready    = (owner == OWN_IC);
                dc_ready    = (owner == OWN_DC);
            end
            default: ;
        endcase
    end

    assign mem.op      = op_r;
    assign mem.address = addr_r;
    assign mem.wdata   = wdata_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner       <= OWN_IC;
            last_grant  <= OWN_IC;
            op_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            wait_cnt    <= '0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
            ic_data     <= '0;
            dc_rdata    <= '0;
        end else begin
            // Operands are latched at grant; later client changes are ignored.
            if (grant_dc) begin
                owner      <= OWN_DC;
                last_grant <= OWN_DC;
                op_r       <= dc_op;
                addr_r     <= dc_address;
                wdata_r    <= dc_wdata;
            end else if (grant_ic) begin
                owner      <= OWN_IC;
                last_grant <= OWN_IC;
                op_r       <= 1'b0;
                addr_r     <= ic_address;
                wdata_r    <= '0;
            end

            if (state == S_ISSUE)     wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 8'd1;

            if (state == S_WAIT) begin
                if (mem.data_ready) begin
                    abort <= 1'b0;
                    if (!op_r) begin
                        if (owner == OWN_DC) dc_rdata <= mem.rdata;
                        else                 ic_data  <= mem.rdata;
                    end
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    abort       <= 1'b1;
                    timeout_err <= 1'b1;
                    if (owner == OWN_DC) dc_rdata <= '0;
                    else                 ic_data  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_memory_requester.sv
// Self-checking bench for memory_requester: directed protocol cases plus randomized
// rounds against a line-level memory/arbitration reference model.
module tb_memory_requester;
    localparam int LW = 128;
    localparam int AW = 32;
    localparam int TO = 64;

    logic          clk;
    logic          rst;
    logic          ic_req;
    logic [AW-1:0] ic_address;
    logic          ic_ready;
    logic [LW-1:0] ic_data;
    logic          dc_req;
    logic          dc_op;
    logic [AW-1:0] dc_address;
    logic [LW-1:0] dc_wdata;
    logic          dc_ready;
    logic [LW-1:0] dc_rdata;
    logic          timeout_err;

    memory_requester_if #(.CACHE_LINE_SIZE(LW), .MEMORY_ADDRESS_SIZE(AW)) mif ();

    memory_requester #(.CACHE_LINE_SIZE(LW), .MEMORY_ADDRESS_SIZE(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_address(ic_address), .ic_ready(ic_ready), .ic_data(ic_data),
        .dc_req(dc_req), .dc_op(dc_op), .dc_address(dc_address), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata), .timeout_err(timeout_err),
        .mem(mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory model storage and reference storage
    logic [LW-1:0] mem_array [logic [AW-1:0]];
    logic [LW-1:0] ref_mem   [logic [AW-1:0]];
    int            m_lat = 5;

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0101_0101};
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_line(a);
    endfunction

    // Memory responder: data_ready m_lat edges after op_init, held until op_done; m_lat=0 never answers.
    initial begin : mem_model
        bit            m_busy;
        int            m_cnt;
        logic          m_op;
        logic [AW-1:0] m_addr;
        logic [LW-1:0] m_wdata;
        m_busy = 0;
        m_cnt  = 0;
        mif.data_ready = 1'b0;
        mif.rdata      = '0;
        forever begin
            @(posedge clk);
            if (mif.data_ready && mif.op_done) mif.data_ready <= 1'b0;
            if (mif.enable && mif.op_init) begin
                m_busy  = 1;
                m_cnt   = m_lat;
                m_op    = mif.op;
                m_addr  = mif.address;
                m_wdata = mif.wdata;
            end else if (m_busy && m_cnt != 0) begin
                if (m_cnt == 1) begin
                    m_busy = 0;
                    if (m_op) mem_array[m_addr] = m_wdata;
                    else mif.rdata <= mem_array.exists(m_addr) ? mem_array[m_addr] : init_line(m_addr);
                    mif.data_ready <= 1'b1;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Observation state, updated once per cycle at the falling edge
    int            cyc = 0;
    int            n_init = 0, n_done = 0, n_icr = 0, n_dcr = 0;
    int            last_init_cyc = 0, last_done_cyc = 0, ic_rdy_cyc = 0, dc_rdy_cyc = 0;
    int            n_done_at_init = 0;
    int            stab_err = 0, ovl_err = 0, relaunch_err = 0;
    logic          cur_op;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] cur_wdata;
    logic [LW-1:0] ic_got, dc_got;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (mif.op_init) begin
            n_init++;
            last_init_cyc  = cyc;
            n_done_at_init = n_done;
            cur_op    = mif.op;
            cur_addr  = mif.address;
            cur_wdata = mif.wdata;
            if (mif.data_ready) relaunch_err++;
        end else if (mif.enable &&
                     (mif.op !== cur_op || mif.address !== cur_addr || mif.wdata !== cur_wdata)) begin
            stab_err++;
        end
        if (mif.op_done) begin
            n_done++;
            last_done_cyc = cyc;
            if (mif.enable) ovl_err++;
        end
        if (ic_ready) begin
            n_icr++;
            ic_rdy_cyc = cyc;
            ic_got = ic_data;
            ic_req = 1'b0;
        end
        if (dc_ready) begin
            n_dcr++;
            dc_rdy_cyc = cyc;
            dc_got = dc_rdata;
            dc_req = 1'b0;
        end
    endtask

    task automatic serve(input string tag, input int budget);
        int t;
        t = 0;
        while ((ic_req || dc_req) && t < budget) begin
            tick();
            t++;
        end
        check({tag, "_completed"}, 128'(ic_req | dc_req), 128'd0);
        ic_req = 1'b0;
        dc_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 128'({ic_ready, dc_ready, timeout_err, mif.enable, mif.op,
                                    mif.op_init, mif.op_done}), 128'd0);
        check({tag, "_ic_data"}, ic_data, 128'd0);
        check({tag, "_dc_rdata"}, dc_rdata, 128'd0);
        check({tag, "_mem_addr"}, 128'(mif.address), 128'd0);
        check({tag, "_mem_wdata"}, mif.wdata, 128'd0);
    endtask

    localparam logic [LW-1:0] LINE_40 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [LW-1:0] WLINE   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    initial begin : main
        int            n0, d0, exp_icr, exp_dcr, t;
        bit            exp_last_dc;
        logic [LW-1:0] exp_ic_hold, exp_dc_hold;
        rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_op = 1'b0;
        ic_address = '0; dc_address = '0; dc_wdata = '0;
        exp_icr = 0; exp_dcr = 0;
        mem_array[32'h40] = LINE_40;
        ref_mem[32'h40]   = LINE_40;

        // Reset state
        tick(); tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        exp_last_dc = 0; exp_ic_hold = '0; exp_dc_hold = '0;
        tick();

        // Single icache read with a 5-cycle memory
        m_lat = 5; n0 = n_init; d0 = n_done;
        ic_req = 1'b1; ic_address = 32'h40; exp_icr++;
        serve("ic_read", 200);
        exp_last_dc = 0; exp_ic_hold = LINE_40;
        check("ic_read_inits", 128'(n_init - n0), 128'd1);
        check("ic_read_op", 128'(cur_op), 128'd0);
        check("ic_read_addr", 128'(cur_addr), 128'h40);
        check("ic_read_data", ic_got, LINE_40);
        check("ic_read_latency", 128'(ic_rdy_cyc - last_init_cyc), 128'(m_lat + 2));
        check("ic_read_done_cyc", 128'(last_done_cyc), 128'(ic_rdy_cyc));
        check("ic_read_dones", 128'(n_done - d0), 128'd1);
        tick();
        check("ic_ready_single_pulse", 128'(n_icr), 128'(exp_icr));

        // dcache write then read back
        m_lat = 3; n0 = n_init;
        dc_req = 1'b1; dc_op = 1'b1; dc_address = 32'h80; dc_wdata = WLINE; exp_dcr++;
        serve("dc_write", 200);
        ref_mem[32'h80] = WLINE; exp_last_dc = 1;
        check("dc_write_op", 128'(cur_op), 128'd1);
        check("dc_write_wdata", cur_wdata, WLINE);
        check("dc_write_rdata_kept", dc_rdata, exp_dc_hold);
        check("dc_write_inits", 128'(n_init - n0), 128'd1);
        dc_req = 1'b1; dc_op = 1'b0; dc_address = 32'h80; dc_wdata = '0; exp_dcr++;
        serve("dc_readback", 200);
        exp_dc_hold = ref_line(32'h80);
        check("dc_readback_data", dc_got, exp_dc_hold);

        // Arbitration after reset: dcache first, then icache; second pair again dcache first
        rst = 1'b1; tick(); tick();
        check_reset_outputs("reset2");
        rst = 1'b0; exp_last_dc = 0; exp_ic_hold = '0; exp_dc_hold = '0;
        tick();
        for (int p = 0; p < 2; p++) begin
            m_lat = 2 + p; n0 = n_init;
            ic_req = 1'b1; ic_address = 32'h300 + 32'(p * 32);
            dc_req = 1'b1; dc_op = 1'b0; dc_address = 32'h310 + 32'(p * 32);
            exp_icr++; exp_dcr++;
            serve("arb_pair", 300);
            check("arb_dc_first", 128'(dc_rdy_cyc < ic_rdy_cyc), 128'd1);
            check("arb_two_inits", 128'(n_init - n0), 128'd2);
            check("arb_ic_data", ic_got, ref_line(ic_address));
            check("arb_dc_data", dc_got, ref_line(dc_address));
            exp_last_dc = 0;
            exp_ic_hold = ic_got; exp_dc_hold = dc_got;
        end

        // Timeout: memory never answers
        m_lat = 0; d0 = n_done;
        ic_req = 1'b1; ic_address = 32'h100; exp_icr++;
        serve("timeout", 400);
        exp_last_dc = 0; exp_ic_hold = '0;
        check("timeout_latency", 128'(ic_rdy_cyc - last_init_cyc), 128'(TO + 1));
        check("timeout_data_zero", ic_got, 128'd0);
        check("timeout_err_set", 128'(timeout_err), 128'd1);
        check("timeout_no_op_done", 128'(n_done - d0), 128'd0);
        m_lat = 4;
        dc_req = 1'b1; dc_op = 1'b0; dc_address = 32'h120; exp_dcr++;
        serve("after_timeout", 200);
        exp_last_dc = 1; exp_dc_hold = ref_line(32'h120);
        check("after_timeout_data", dc_got, exp_dc_hold);
        check("timeout_err_sticky", 128'(timeout_err), 128'd1);

        // Reset in the middle of WAIT; the late response must be drained before a new issue
        m_lat = 10; n0 = n_init;
        ic_req = 1'b1; ic_address = 32'h200;
        t = 0;
        while (n_init == n0 && t < 50) begin tick(); t++; end
        check("rst_wait_issued", 128'(n_init - n0), 128'd1);
        tick(); tick(); tick();
        rst = 1'b1; ic_req = 1'b0;
        tick();
        check_reset_outputs("rst_mid_wait");
        rst = 1'b0; exp_last_dc = 0; exp_ic_hold = '0; exp_dc_hold = '0;
        d0 = n_done;
        t = 0;
        while (!mif.data_ready && t < 50) begin tick(); t++; end
        check("rst_stale_ready_seen", 128'(mif.data_ready), 128'd1);
        m_lat = 2;
        ic_req = 1'b1; ic_address = 32'h210; exp_icr++;
        serve("after_rst", 200);
        exp_ic_hold = ref_line(32'h210);
        check("drain_before_issue", 128'(n_done_at_init - d0), 128'd1);
        check("after_rst_data", ic_got, exp_ic_hold);

        // Back-to-back icache reads: one idle cycle between op_done and the next op_init
        m_lat = 3; n0 = n_init;
        ic_req = 1'b1; ic_address = 32'h00; exp_icr++;
        serve("b2b_first", 200);
        d0 = last_done_cyc;
        ic_req = 1'b1; ic_address = 32'h10; exp_icr++;
        serve("b2b_second", 200);
        exp_ic_hold = ref_line(32'h10);
        check("b2b_gap", 128'(last_init_cyc - d0), 128'd2);
        check("b2b_inits", 128'(n_init - n0), 128'd2);
        check("b2b_data", ic_got, exp_ic_hold);

        // Randomized rounds against the reference model
        for (int r = 0; r < 24; r++) begin
            bit            want_ic, want_dc, dc_first;
            int            mode;
            mode    = int'($urandom_range(1, 3));
            want_ic = (mode & 1) != 0;
            want_dc = (mode & 2) != 0;
            m_lat   = int'($urandom_range(1, 6));
            ic_address = 32'h1000 + 32'($urandom_range(0, 3) * 16);
            dc_address = 32'h1000 + 32'($urandom_range(0, 3) * 16);
            dc_op      = 1'($urandom_range(0, 1));
            dc_wdata   = {$urandom, $urandom, $urandom, $urandom};
            dc_first   = want_dc && (!want_ic || !exp_last_dc);
            if (dc_first) begin
                if (dc_op) ref_mem[dc_address] = dc_wdata;
                else exp_dc_hold = ref_line(dc_address);
                exp_last_dc = 1;
            end
            if (want_ic) begin
                exp_ic_hold = ref_line(ic_address);
                exp_last_dc = 0;
            end
            if (want_dc && !dc_first) begin
                if (dc_op) ref_mem[dc_address] = dc_wdata;
                else exp_dc_hold = ref_line(dc_address);
                exp_last_dc = 1;
            end
            n0 = n_init;
            ic_req = want_ic; dc_req = want_dc;
            if (want_ic) exp_icr++;
            if (want_dc) exp_dcr++;
            serve("rand", 300);
            check("rand_inits", 128'(n_init - n0), 128'(32'(want_ic) + 32'(want_dc)));
            if (want_ic) check("rand_ic_data", ic_data, exp_ic_hold);
            if (want_dc) check("rand_dc_rdata", dc_rdata, exp_dc_hold);
            if (want_ic && want_dc) check("rand_order", 128'(dc_rdy_cyc < ic_rdy_cyc), 128'(dc_first));
        end

        tick(); tick();
        check("ic_ready_pulses", 128'(n_icr), 128'(exp_icr));
        check("dc_ready_pulses", 128'(n_dcr), 128'(exp_dcr));
        check("operand_stability", 128'(stab_err), 128'd0);
        check("op_done_with_enable", 128'(ovl_err), 128'd0);
        check("relaunch_with_ready", 128'(relaunch_err), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/memory_requester.md
Name: memory_requester

Overview:
- Initiator side of the main-memory line protocol; the memory block is the responder.
- Accepts line requests from two clients: instruction cache (read-only) and data cache (read/write).
- Arbitrates round-robin between them and drives one memory transaction at a time: enable/op/address/data, op_init, op_done.
- Returns the fetched line, or a write acknowledge, to the owning client as a one-cycle ready pulse.

Parameters:
- CACHE_LINE_SIZE, 128, line width in bits (memory data_in/data_out width)
- MEMORY_ADDRESS_SIZE, 32, byte address width
- TIMEOUT_CYCLES, 64, max cycles in WAIT before abort; 8-bit counter, legal range 1..255

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ic_req  in  1  icache line-read request, held until ic_ready
- ic_address  in  MEMORY_ADDRESS_SIZE  icache line address
- ic_ready  out  1  one-cycle pulse: ic_data valid
- ic_data  out  CACHE_LINE_SIZE  line returned to icache
- dc_req  in  1  dcache request, held until dc_ready
- dc_op  in  1  0 = read, 1 = write
- dc_address  in  MEMORY_ADDRESS_SIZE  dcache line address
- dc_wdata  in  CACHE_LINE_SIZE  line to write
- dc_ready  out  1  one-cycle pulse: read data valid or write complete
- dc_rdata  out  CACHE_LINE_SIZE  line returned to dcache
- mem_enable  out  1  to memory enable
- mem_op  out  1  to memory op
- mem_address  out  MEMORY_ADDRESS_SIZE  to memory address
- mem_wdata  out  CACHE_LINE_SIZE  to memory data_in
- mem_op_init  out  1  to memory op_init, one-cycle pulse at issue
- mem_op_done  out  1  to memory op_done, one-cycle pulse after data_ready
- mem_rdata  in  CACHE_LINE_SIZE  from memory data_out
- mem_data_ready  in  1  from memory data_ready, level, held until op_done sampled
- timeout_err  out  1  sticky abort flag, cleared only by rst

Behaviour:

Reset:
- Every output is 0, including data buses.
- State goes to IDLE; last_grant = IC, so the dcache wins the first tie.
- Timeout counter cleared.
- Reset mid-transaction drops mem_enable the next edge; the in-flight request is lost, and clients re-request.

FSM state IDLE → DRAIN / ISSUE:
- If mem_data_ready=1 (stale from reset or abort), go to DRAIN.
- Otherwise, if any req is high: grant dc if only dc, ic if only ic, or the one that is not last_grant if both.
- On grant: latch owner, op (ic forces 0), address and wdata into mem_* regs; set last_grant = owner; go to ISSUE.

DRAIN:
- Pulse mem_op_done=1 with mem_enable=0.
- Return to IDLE; no issue until mem_data_ready is 0.

ISSUE (1 cycle):
- mem_enable=1, mem_op_init=1.
- Go to WAIT with timeout counter = 0.

WAIT:
- mem_enable held at 1; mem_op_init=0; mem_op, mem_address and mem_wdata stable throughout.
- Counter increments each cycle.
- On sampling mem_data_ready=1:
  - mem_enable←0, mem_op_done←1.
  - If read, capture mem_rdata into the owner's data output.
  - Owner's ready←1; go to DONE.
- On counter reaching TIMEOUT_CYCLES-1 without data_ready:
  - mem_enable←0, timeout_err←1.
  - Owner's ready←1 with data output = 0; go to DONE.

DONE (1 cycle):
- mem_op_done←0, ready←0; go to IDLE.

Latency and throughput:
- Read latency from req sampled in IDLE to ready pulse = 2 + memory response cycles.
- Minimum gap between transactions is 1 idle cycle. The memory sees op_done before enable can rise again, which prevents it re-launching the old op.

Data outputs and requests:
- ic_data / dc_rdata hold their last value until the next read completion for that client. Write completion leaves dc_rdata unchanged.
- Clients keep req and operands stable until ready and drop req the cycle after. The requester uses only latched copies, so operand changes after grant are ignored.
- A req still high in IDLE after DONE is treated as a new request.
- A req of the non-owner arriving during ISSUE/WAIT/DONE waits; the next arbitration favours it.

Test Plan:
- ic_req, ic_address=0x40; memory model returns 0x00112233_44556677_8899AABB_CCDDEEFF after 5 cycles → single mem_op_init, mem_op=0, mem_address=0x40; ic_ready one pulse with that data; mem_op_done pulse the cycle after data_ready; mem_enable low by then.
- dc_req, dc_op=1, dc_address=0x80, dc_wdata=0xDEADBEEF_…_CAFEF00D → mem_op=1, mem_wdata matches; dc_ready pulse; dc_rdata unchanged; a later dc read of 0x80 returns the written line.
- ic_req and dc_req both raised the same cycle after reset → dc granted first, ic second; then both again → dc first (last_grant=ic after 2nd); exactly 2 op_init pulses per pair.
- Memory model never asserts data_ready → after 64 WAIT cycles mem_enable drops; timeout_err=1 and sticky; owner ready pulses with data 0; next request still completes normally.
- rst asserted mid-WAIT while the model later raises data_ready → all outputs 0 after reset edge; DRAIN pulses mem_op_done before any new mem_op_init.
- Back-to-back ic reads 0x00, 0x10 → exactly one idle cycle between the first mem_op_done and the second mem_op_init; no duplicate memory operation.
